lsu_mem_ctrl: RTL and testbench

// - Memory-stage load/store controller; issues the M-stage access to a variable-latency data memory over a req/ack handshake.
// - Produces stall_mem toward the hazard logic, which uses it to hold F/D/E/M. Honours kill_m, the M-stage flush.
// - Formats load data (LB/LH/LW/LBU/LHU) and store byte lanes (SB/SH/SW).

---
 rtl/lsu_mem_ctrl_if.sv | 26 ++
 rtl/lsu_mem_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Memory-side bus of the load/store controller: request, address, data, byte enables, ack, read data.
// Latency: none, plain wires between controller and data memory.
// Backpressure: mem_req/mem_addr/mem_we/mem_wdata/mem_be stay stable until the memory answers with mem_ack.
//
// Ports (modports):
//   master (controller): drives mem_req, mem_we, mem_addr, mem_wdata, mem_be; samples mem_ack, mem_rdata
//   slave  (memory)    : samples the request fields; drives mem_ack, mem_rdata
interface lsu_mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// M-stage load/store controller: issues one access to a variable-latency memory and formats load data / store lanes.
// Latency: ack in the k-th request cycle gives k+1 stall cycles; result (ld_validM / bus_err / misalign) shows in DONE.
// Backpressure: stall_mem holds F/D/E/M while the access is outstanding; the request is held until mem_ack or TIMEOUT.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_rdenM, mem_wrenM      M-stage load / store
//   kill_m                    M-stage flush
//   addrM, wdataM, funct3M    byte address, store data, access size/sign
//   stall_mem                 hold the pipeline
//   ld_dataM, ld_validM       formatted load data and its one-cycle valid pulse
//   bus_err                   one-cycle pulse on timeout abort
//   misalign                  one-cycle pulse on a trapped misaligned access
//   mem (master modport)      request/ack bus toward data memory
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned LH/LHU/SH/LW/SW instead of issuing them.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_rdenM,
  input  logic                 mem_wrenM,
  input  logic                 kill_m,
  input  logic [31:0]          addrM,
  input  logic [31:0]          wdataM,
  input  logic [2:0]           funct3M,
  output logic                 stall_mem,
  output logic [31:0]          ld_dataM,
  output logic                 ld_validM,
  output logic                 bus_err,
  output logic                 misalign,
  lsu_mem_ctrl_if.master       mem
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic          err_q;
  logic          kill_q;

  logic          acc;
  logic          cnt_last;
  logic [3:0]    be_in;
  logic [31:0]   wdata_in;
  logic [31:0]   ld_fmt;

  // Load data formatting: pick the byte/half addressed by a and extend it.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b010:  fmt_load = w;
      3'b100:  fmt_load = {24'd0, b};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = 32'd0;
    endcase
  endfunction

  assign acc      = (mem_rdenM | mem_wrenM) & ~kill_m;
  assign cnt_last = (cnt == CW'(TIMEOUT - 1));

  // Store lanes are computed from the live M-stage inputs and latched at issue.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = wdataM;
    if (mem_wrenM) begin
      case (funct3M[1:0])
        2'b00: begin
          be_in    = 4'b0001 << addrM[1:0];
          wdata_in = {4{wdataM[7:0]}};
        end
        2'b01: begin
          be_in    = addrM[1] ? 4'b1100 : 4'b0011;
          wdata_in = {2{wdataM[15:0]}};
        end
        default: begin
          be_in    = 4'b1111;
          wdata_in = wdataM;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_in;
  logic mis_q;

  always_comb begin
    mis_in = 1'b0;
    if (funct3M == 3'b001 || funct3M == 3'b101) mis_in = addrM[0];
    else if (funct3M == 3'b010)                 mis_in = |addrM[1:0];
  end
`endif

  assign ld_fmt = fmt_load(mem.mem_rdata, f3_q, addr_q[1:0]);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (acc) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_nx = mis_in ? DONE : REQ;
`else
          state_nx = REQ;
`endif
        end
      end
      REQ: begin
        if (mem.mem_ack || cnt_last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      kill_q   <= 1'b0;
      ld_dataM <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (acc) begin
            addr_q  <= addrM;
            wdata_q <= wdata_in;
            be_q    <= be_in;
            f3_q    <= funct3M;
            we_q    <= mem_wrenM;
            err_q   <= 1'b0;
            kill_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= mis_in;
`endif
          end
        end
        REQ: begin
          // A flush while waiting cannot cancel the bus cycle; it only suppresses the load result.
          if (kill_m) kill_q <= 1'b1;
          if (mem.mem_ack) begin
            ld_dataM <= (!we_q && !kill_q && !kill_m) ? ld_fmt : 32'd0;
          end else if (cnt_last) begin
            err_q    <= 1'b1;
            ld_dataM <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall ends on DONE so the pipeline advances in the same cycle the result is presented.
  assign stall_mem = (state == REQ) | (acc & (state == IDLE));

  assign mem.mem_req   = (state == REQ);
  assign mem.mem_we    = (state == REQ) & we_q;
  assign mem.mem_be    = (state == REQ) ? be_q : 4'b0000;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata = wdata_q;

  assign bus_err = (state == DONE) & err_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = (state == DONE) & mis_q;
  assign ld_validM = (state == DONE) & ~we_q & ~err_q & ~kill_q & ~mis_q;
`else
  assign misalign  = 1'b0;
  assign ld_validM = (state == DONE) & ~we_q & ~err_q & ~kill_q;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed loads/stores against a small ack-delay memory model.
// Expected events are queued by the stimulus; a negedge monitor pops and compares each observed event.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-word case.
module tb_lsu_mem_ctrl;

  localparam int K_REQ = 0, K_RLEN = 1, K_STALL = 2, K_LD = 3, K_ERR = 4, K_MIS = 5;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rdenM = 1'b0, mem_wrenM = 1'b0, kill_m = 1'b0;
  logic [31:0] addrM = '0, wdataM = '0;
  logic [2:0]  funct3M = '0;
  logic        stall_mem, ld_validM, bus_err, misalign;
  logic [31:0] ld_dataM;

  logic        ack_m = 1'b0, late_ack = 1'b0;
  logic [31:0] rdata_v = '0;
  int          ack_at_v = 0;
  int          rcnt = 0;

  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;
  ev_t q[$];

  lsu_mem_ctrl_if bus();

  assign bus.mem_ack   = ack_m | late_ack;
  assign bus.mem_rdata = rdata_v;

  lsu_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rdenM (mem_rdenM),
    .mem_wrenM (mem_wrenM),
    .kill_m    (kill_m),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .funct3M   (funct3M),
    .stall_mem (stall_mem),
    .ld_dataM  (ld_dataM),
    .ld_validM (ld_validM),
    .bus_err   (bus_err),
    .misalign  (misalign),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  // Memory model: ack during the ack_at_v-th request cycle (0 = never).
  initial forever begin
    @(posedge clk); #1;
    if (bus.mem_req) begin
      rcnt++;
      ack_m = (rcnt == ack_at_v);
    end else begin
      rcnt  = 0;
      ack_m = 1'b0;
    end
  end

  task automatic push(input int k, input logic [31:0] v, input logic [3:0] be = 4'b0,
                      input logic we = 1'b0, input logic [31:0] wd = 32'd0);
    ev_t e;
    e.kind = k; e.val = v; e.be = be; e.we = we; e.wd = wd;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ev(input int k, input logic [31:0] v, input logic [3:0] be,
                        input logic we, input logic [31:0] wd);
    ev_t e;
    bit  bad;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected event kind=%0d val=%h at %0t", k, v, $time);
    end else begin
      e   = q.pop_front();
      bad = (e.kind != k) || (e.val !== v);
      if (k == K_REQ && e.kind == K_REQ)
        bad = bad || (e.be !== be) || (e.we !== we) || (we && e.wd !== wd);
      if (bad) begin
        n_err++;
        $display("FAIL event at %0t: got kind=%0d val=%h be=%b we=%b wd=%h, expected kind=%0d val=%h be=%b we=%b wd=%h",
                 $time, k, v, be, we, wd, e.kind, e.val, e.be, e.we, e.wd);
      end
    end
  endtask

  // Monitor: request start, request length, stall run length, and result pulses.
  initial begin
    bit prev_req = 1'b0;
    int req_len = 0;
    int stall_len = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.mem_req && !prev_req)
          chk_ev(K_REQ, bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata);
        if (bus.mem_req) req_len++;
        else if (prev_req) begin
          chk_ev(K_RLEN, req_len, 4'b0, 1'b0, 32'd0);
          req_len = 0;
        end
        if (stall_mem) stall_len++;
        else if (stall_len > 0) begin
          chk_ev(K_STALL, stall_len, 4'b0, 1'b0, 32'd0);
          stall_len = 0;
        end
        if (ld_validM) chk_ev(K_LD,  ld_dataM, 4'b0, 1'b0, 32'd0);
        if (bus_err)   chk_ev(K_ERR, ld_dataM, 4'b0, 1'b0, 32'd0);
        if (misalign)  chk_ev(K_MIS, 32'd0,    4'b0, 1'b0, 32'd0);
        prev_req = bus.mem_req;
      end
    end
  end

  // Drive one M-stage access and hold it until the controller releases the stall.
  task automatic do_acc(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rdata,
                        input int kill_at);
    int  n;
    bit  done;
    ack_at_v  = ack_at;
    rdata_v   = rdata;
    mem_rdenM = rd; mem_wrenM = wr; funct3M = f3; addrM = a; wdataM = wd;
    n = 0; done = 1'b0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (n == kill_at) kill_m = 1'b1;
      if (!stall_mem) done = 1'b1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL access_timeout: stall_mem still 1 after %0d cycles, expected release", n);
    end
    @(posedge clk); #1;
    mem_rdenM = 1'b0; mem_wrenM = 1'b0; kill_m = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_ld(input logic [2:0] f3, input logic [31:0] a, input int ack_at,
                        input logic [31:0] rdata, input logic [31:0] exp);
    push(K_REQ, {a[31:2], 2'b00}, 4'b1111, 1'b0, 32'd0);
    push(K_RLEN, ack_at);
    push(K_STALL, ack_at + 1);
    push(K_LD, exp);
    do_acc(1'b1, 1'b0, f3, a, 32'h5555_5555, ack_at, rdata, 0);
  endtask

  task automatic run_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [3:0] be, input logic [31:0] wexp);
    push(K_REQ, {a[31:2], 2'b00}, be, 1'b1, wexp);
    push(K_RLEN, ack_at);
    push(K_STALL, ack_at + 1);
    do_acc(1'b0, 1'b1, f3, a, wd, ack_at, 32'h0, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req",   bus.mem_req,   1'b0);
    chk("rst_mem_we",    bus.mem_we,    1'b0);
    chk("rst_mem_be",    bus.mem_be,    4'b0000);
    chk("rst_ld_valid",  ld_validM,     1'b0);
    chk("rst_bus_err",   bus_err,       1'b0);
    chk("rst_ld_data",   ld_dataM,      32'd0);
    chk("rst_stall",     stall_mem,     1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Loads
    run_ld(3'b010, 32'h100, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_ld(3'b000, 32'h103, 1, 32'h8011_2233, 32'hFFFF_FF80);
    run_ld(3'b100, 32'h103, 1, 32'h8011_2233, 32'h0000_0080);
    run_ld(3'b101, 32'h102, 2, 32'h8011_2233, 32'h0000_8011);
    run_ld(3'b001, 32'h102, 1, 32'h8011_2233, 32'hFFFF_8011);
    run_ld(3'b000, 32'h101, 1, 32'h8011_2233, 32'h0000_0022);
    run_ld(3'b011, 32'h100, 1, 32'h8011_2233, 32'h0000_0000);

    // Stores
    run_st(3'b001, 32'h206, 32'h0000_ABCD, 1, 4'b1100, 32'hABCD_ABCD);
    run_st(3'b000, 32'h101, 32'h0000_0077, 2, 4'b0010, 32'h7777_7777);
    run_st(3'b010, 32'h300, 32'h1234_5678, 1, 4'b1111, 32'h1234_5678);

    // Timeout: 16 request cycles, error pulse with zeroed data, no load valid
    push(K_REQ, 32'h108, 4'b1111, 1'b0, 32'd0);
    push(K_RLEN, 16);
    push(K_STALL, 17);
    push(K_ERR, 32'd0);
    do_acc(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 0, 32'h1111_1111, 0);

    // Store flushed in request cycle 2, ack in cycle 4: still runs to ack
    push(K_REQ, 32'h300, 4'b1111, 1'b1, 32'h1234_5678);
    push(K_RLEN, 4);
    push(K_STALL, 5);
    do_acc(1'b0, 1'b1, 3'b010, 32'h300, 32'h1234_5678, 4, 32'h0, 2);
    chk("kill_st_idle_req", bus.mem_req, 1'b0);

    // Load flushed in request cycle 1: data discarded
    push(K_REQ, 32'h104, 4'b1111, 1'b0, 32'd0);
    push(K_RLEN, 2);
    push(K_STALL, 3);
    do_acc(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 2, 32'hAAAA_5555, 1);

    // Flush in IDLE: no request, no stall
    mem_rdenM = 1'b1; kill_m = 1'b1; funct3M = 3'b010; addrM = 32'h400;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("kill_idle_req",   bus.mem_req, 1'b0);
      chk("kill_idle_stall", stall_mem,   1'b0);
    end
    mem_rdenM = 1'b0; kill_m = 1'b0;
    @(posedge clk); #1;

    // Reset during REQ: request drops, late ack ignored
    push(K_REQ, 32'h100, 4'b1111, 1'b0, 32'd0);
    push(K_RLEN, 3);
    push(K_STALL, 4);
    ack_at_v = 0;
    mem_rdenM = 1'b1; funct3M = 3'b010; addrM = 32'h100;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; mem_rdenM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_req_drop", bus.mem_req, 1'b0);
    late_ack = 1'b1; rdata_v = 32'h7777_0000;
    @(posedge clk); #1;
    late_ack = 1'b0;
    chk("late_ack_req",   bus.mem_req, 1'b0);
    chk("late_ack_valid", ld_validM,   1'b0);
    @(posedge clk); #1;

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    push(K_STALL, 1);
    push(K_MIS, 32'd0);
    do_acc(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 1, 32'hCAFE_F00D, 0);
`else
    run_ld(3'b010, 32'h101, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("events_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
